// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
// Imported by regfile_sb and regfile_sb_busy.
package regfile_pkg;

    localparam int DATA_W_DEF = 20;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
    localparam int NREAD_DEF  = 2;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

    // True when addr names the hardwired zero register of this build.
    function automatic bit is_zero_reg(input int addr, input int zero_reg);
        return (zero_reg != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_sb_busy.sv
// Per-register pending-write bits with issue-over-writeback priority.
// Also reduces the vector to a single drain indicator.
module regfile_sb_busy
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   issue_en,
    input  logic [ADDR_W-1:0]      issue_addr,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic                   any_busy
);

    localparam int N_REGS = 2 ** ADDR_W;

    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < N_REGS; r++) begin
                // A new producer wins over a retiring one on the same edge.
                if (is_zero_reg(r, ZERO_REG)) begin
                    busy[r] <= 1'b0;
                end else if (issue_en && (issue_addr == ADDR_W'(r))) begin
                    busy[r] <= 1'b1;
                end else if (wb_en && (wb_addr == ADDR_W'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    assign any_busy = |busy;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int ZERO_REG = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    issue_en,
    input  logic [ADDR_W-1:0]       issue_addr,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    any_busy
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [N_REGS];
    logic [N_REGS-1:0] busy;
    logic              wb_zero;
    logic              wr_en;

    assign wb_zero = (ZERO_REG != 0) && (wb_addr == '0);
    assign wr_en   = wb_en && !wb_zero;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < N_REGS; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[wb_addr] <= wb_data;
        end
    end

    regfile_sb_busy #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clock      (clock),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .busy       (busy),
        .any_busy   (any_busy)
    );

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        logic              z;

        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign z = (ZERO_REG != 0) && (a == '0);

`ifdef RF_BYPASS_EN
        // Writeback in flight this cycle supersedes the stored word and busy bit.
        logic hit;
        assign hit = wr_en && (wb_addr == a);
        assign d   = z ? '0 : (hit ? wb_data : mem[a]);
        assign b   = !z && !hit && busy[a];
`else
        assign d = z ? '0 : mem[a];
        assign b = !z && busy[a];
`endif

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k]                  = b;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register pending-write scoreboard for the pipelined processor. It replaces the fixed 16×20-bit, two-read-port register file in the decode stage. Width, depth and read-port count are generalised. It adds synchronous reset, an optional hardwired zero register, and busy tracking so the hazard unit can stall on outstanding writebacks. An optional writeback-to-read bypass is selectable at compile time.

## Interface
- DATA_W, 20, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 0, when 1 register 0 reads as zero, ignores writes and is never busy
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NREAD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NREAD  port k's register has an outstanding write
- issue_en  in  1  instruction with destination leaves decode
- issue_addr  in  ADDR_W  destination register being issued
- wb_en  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- any_busy  out  1  OR of all busy bits (drain indicator)

## Operation
- Storage: 2**ADDR_W registers of DATA_W bits, plus one busy bit per register.
- Reset (reset=1 at a rising edge):
  - all registers and busy bits cleared;
  - wb_en and issue_en ignored that cycle;
  - applies mid-operation: outstanding busy bits are dropped.
- Write: at a rising edge with wb_en=1, reg[wb_addr] <= wb_data. No write if ZERO_REG=1 and wb_addr=0.
- Busy bit per register r, evaluated each edge in this priority order:
  1. reset → 0
  2. issue_en and issue_addr=r → 1
  3. wb_en and wb_addr=r → 0
  4. otherwise hold
- Issue and writeback to the same register in the same cycle leave busy=1: the new producer is outstanding.
- Issue to an already-busy register: busy stays 1. There is no counting; the latest writeback clears it.
- Writeback to a non-busy register: data written, busy stays 0. Legal.
- Reads are combinational from the stored array. Each port is independent, and any ports may share an address.
- rd_busy[k] = busy[rd_addr_k] (subject to bypass, see Configuration).
- ZERO_REG=1 with rd_addr_k=0: rd_data=0 and rd_busy=0, regardless of issue activity.
- any_busy is the combinational OR of all busy bits.

## Timing
- Read latency 0 cycles (address to data combinational). Write latency 1 edge.
- Issue takes effect on rd_busy the cycle after issue_en.
- Outputs after reset: rd_data=0 for every address, rd_busy=0, any_busy=0.
- Issue and writeback need no handshake. Both are single-cycle strobes sampled at each rising edge.

## Configuration
- RF_BYPASS_EN defined: when wb_en=1 and wb_addr=rd_addr_k (and not the zero register), rd_data_k=wb_data and rd_busy_k=0 in the same cycle. Same-cycle issue does not affect this.
- RF_BYPASS_EN undefined: rd_data_k and rd_busy_k show the pre-edge state. The written value appears the cycle after writeback.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - the type for a data word and an address;
  - helper localparam DEPTH.
- One sub-module, regfile_sb_busy: the busy-bit vector with its priority update and any_busy reduction. The data array and read muxing stay in the top level.

## Test plan
- Reset: preload via writes, assert reset 1 cycle → every rd_data=0, rd_busy=0, any_busy=0.
- Issue r3, then 2 cycles later writeback r3=20'h00ABC → rd_busy for r3 high for 2 cycles, clears after wb edge. rd_data reads 20'h00ABC the next cycle, or same cycle with RF_BYPASS_EN.
- Same-cycle issue r5 and wb r5=20'h12345 → r5 data updated, rd_busy for r5 stays 1.
- NREAD=3, all ports read r7 holding 20'hFFFFF → all three rd_data=20'hFFFFF.
- ZERO_REG=1: wb r0=20'h00001 and issue r0 → rd_data(r0)=0, rd_busy=0, any_busy=0.
- Reset while r2 and r9 busy → busy cleared next cycle, any_busy=0, a later wb to r2 writes normally.
